// File: rtl/dense_layer_seq_if.sv
// Signal bundle for dense_layer_seq: weight/bias writes, start strobe with input vector,
// and the busy / output_ready / output_data result side.
interface dense_layer_seq_if #(
    parameter int WIDTH    = 16,
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 5,
    parameter int AW       = $clog2(OUT_SIZE*(IN_SIZE+1))
);
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic signed [WIDTH-1:0] wr_data;
    logic                    input_ready;
    logic signed [WIDTH-1:0] input_data  [IN_SIZE];
    logic                    busy;
    logic                    output_ready;
    logic signed [WIDTH-1:0] output_data [OUT_SIZE];

    modport master (
        output wr_en, wr_addr, wr_data, input_ready, input_data,
        input  busy, output_ready, output_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, input_ready, input_data,
        output busy, output_ready, output_data
    );
endinterface

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC per cycle over a writable
// weight/bias RAM, optional ReLU, output saturation, one-cycle completion pulse.
module dense_layer_seq #(
    parameter int WIDTH    = 16,
    parameter int NFRAC    = 10,
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 5,
    parameter int RELU     = 0
) (
    input logic              clk,
    input logic              reset_n,
    dense_layer_seq_if.slave bus
);
    localparam int DEPTH = OUT_SIZE*(IN_SIZE+1);
    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = 2*WIDTH + $clog2(IN_SIZE+1) + 1;
    localparam int IW    = $clog2(IN_SIZE+1);
    localparam int OW    = $clog2(OUT_SIZE+1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [WIDTH-1:0] r_ram [2**AW];
    logic signed [WIDTH-1:0] r_x   [IN_SIZE];
    logic signed [WIDTH-1:0] r_out [OUT_SIZE];
    logic [IW-1:0]           r_i;
    logic [OW-1:0]           r_o;
    logic signed [ACC_W-1:0] r_acc;

    logic [AW-1:0]           w_rd_addr;
    logic signed [WIDTH-1:0] w_rd;
    logic signed [WIDTH-1:0] w_x;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_wr_ok;
    logic                    w_busy;
    logic                    w_out_ready;

    function automatic logic signed [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v);
        if (RELU != 0 && v[ACC_W-1]) return '0;
        return v;
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    // Writes are accepted only while idle and inside the populated address range.
    assign w_wr_ok = reset_n && bus.wr_en && (r_state == S_IDLE) &&
                     ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_ram[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        w_rd_addr = AW'(int'(r_o)*(IN_SIZE+1) + ((r_state == S_BIAS) ? IN_SIZE : int'(r_i)));
        w_x = '0;
        for (int k = 0; k < IN_SIZE; k++) begin
            if (int'(r_i) == k) w_x = r_x[k];
        end
    end

    assign w_rd       = r_ram[w_rd_addr];
    assign w_prod     = w_x * w_rd;
    assign w_prod_ext = ACC_W'(w_prod);
    // Bias is aligned to the product's 2*NFRAC fractional bits before the final floor shift.
    assign w_bias_ext = ACC_W'(w_rd) <<< NFRAC;
    assign w_sum      = r_acc + w_bias_ext;
    assign w_res      = saturate(relu_clamp(w_sum >>> NFRAC));

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.input_ready) w_next = S_MAC;
            S_MAC:  if (r_i == IW'(IN_SIZE-1)) w_next = S_BIAS;
            S_BIAS: w_next = (r_o == OW'(OUT_SIZE-1)) ? S_DONE : S_MAC;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b0;
        w_out_ready = 1'b0;
        if (r_state != S_IDLE) w_busy = 1'b1;
        if (r_state == S_DONE) w_out_ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.input_ready && reset_n) r_x <= bus.input_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i   <= '0;
            r_o   <= '0;
            r_acc <= '0;
            for (int k = 0; k < OUT_SIZE; k++) r_out[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.input_ready) begin
                        r_i   <= '0;
                        r_o   <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_i   <= r_i + IW'(1);
                end
                S_BIAS: begin
                    for (int k = 0; k < OUT_SIZE; k++) begin
                        if (int'(r_o) == k) r_out[k] <= w_res;
                    end
                    r_acc <= '0;
                    r_i   <= '0;
                    if (r_o != OW'(OUT_SIZE-1)) r_o <= r_o + OW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = w_busy;
    assign bus.output_ready = w_out_ready;
    assign bus.output_data  = r_out;
endmodule
